// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the round-robin sequence-detector scheduler.
package seq_det_pkg;

    localparam int unsigned N_CH_DEF  = 4;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned SAT_W     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLR    = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    // Increment that sticks at max instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                  input logic [SAT_W-1:0] max);
        return (val >= max) ? val : val + SAT_W'(1);
    endfunction

endpackage

// File: rtl/seq_det_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester after rr_ptr_i, circularly.
module seq_det_rr_arb
    import seq_det_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEF,
    parameter int unsigned CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CH_W-1:0] rr_ptr_i,
    output logic [N_CH-1:0] gnt_oh_o,
    output logic [CH_W-1:0] gnt_idx_o,
    output logic            any_req_o
);

    logic found;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            if (!found && req_i[CH_W'((32'(rr_ptr_i) + i) % N_CH)]) begin
                found     = 1'b1;
                gnt_idx_o = CH_W'((32'(rr_ptr_i) + i) % N_CH);
            end
        end
        gnt_oh_o[gnt_idx_o] = found;
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/seq_det_sched.sv
// Shares one bit-serial sequence detector among N_CH streams, one whole frame per grant,
// routing match pulses back to the owner and reporting a saturating per-frame hit count.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned CH_W  = $clog2(N_CH),
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  ch_vld,
    input  logic [N_CH-1:0]  ch_din,
    input  logic [N_CH-1:0]  ch_last,
    output logic [N_CH-1:0]  ch_rdy,
    output logic             det_clr,
    output logic             det_vld,
    output logic             det_din,
    input  logic             det_result,
    output logic             hit_vld,
    output logic [CH_W-1:0]  hit_ch,
    output logic             frame_done,
    output logic [CH_W-1:0]  frame_ch,
    output logic [CNT_W-1:0] frame_hits
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CH_W-1:0]  gnt_q, gnt_d;
    logic [N_CH-1:0]  gnt_oh_q, gnt_oh_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_done_q, frame_done_d;
    logic [CH_W-1:0]  frame_ch_q, frame_ch_d;
    logic [CNT_W-1:0] frame_hits_q, frame_hits_d;

    logic [N_CH-1:0]  arb_oh;
    logic [CH_W-1:0]  arb_idx;
    logic             arb_any;
    logic             counted;

    seq_det_rr_arb #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req_i     (ch_vld),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx),
        .any_req_o (arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            gnt_oh_q     <= '0;
            rr_ptr_q     <= CH_W'(N_CH - 1);
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            frame_ch_q   <= '0;
            frame_hits_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gnt_oh_q     <= gnt_oh_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
            frame_ch_q   <= frame_ch_d;
            frame_hits_q <= frame_hits_d;
        end
    end

    // Results are only attributed to a frame while its owner holds the detector.
    assign counted = det_result && ((state_q == STREAM) || (state_q == DRAIN));

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gnt_oh_d     = gnt_oh_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        frame_ch_d   = frame_ch_q;
        frame_hits_d = frame_hits_q;
        ch_rdy       = '0;
        det_clr      = 1'b0;
        det_vld      = 1'b0;
        det_din      = 1'b0;
        hit_vld      = counted;

        if (counted) begin
            cnt_d = CNT_W'(sat_inc(SAT_W'(cnt_q), SAT_W'(CNT_MAX)));
        end

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d    = arb_idx;
                    gnt_oh_d = arb_oh;
                    state_d  = CLR;
                end
            end
            CLR: begin
                det_clr = 1'b1;
                cnt_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                ch_rdy  = gnt_oh_q;
                det_vld = |(ch_vld & gnt_oh_q);
                det_din = |(ch_din & gnt_oh_q);
                if (det_vld && |(ch_last & gnt_oh_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                rr_ptr_d     = gnt_q;
                frame_done_d = 1'b1;
                frame_ch_d   = gnt_q;
                frame_hits_d = cnt_d;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hit_ch     = gnt_q;
    assign frame_done = frame_done_q;
    assign frame_ch   = frame_ch_q;
    assign frame_hits = frame_hits_q;

endmodule
